dram_cmd_arbiter: RTL and testbench

//  Shares the single DRAM command channel (cmd_valid/cmd_type/cmd_data/cmd_ready) between

---
 rtl/dram_cmd_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_dram_cmd_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_arbiter.sv
// Arbitrates the DRAM command channel between the init sequencer, the refresh requester and
// NUM_HOST round-robin hosts, holding the winning command in a single output register.
module dram_cmd_arbiter #(
    parameter  int NUM_HOST         = 4,
    parameter  int REFRESH_MAX_WAIT = 64,
    parameter  int TYPE_W           = 5,
    parameter  int DATA_W           = 32,
    localparam int ID_W             = $clog2(NUM_HOST + 2)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       init_busy,
    input  logic                       init_done,
    input  logic                       init_valid,
    input  logic [TYPE_W-1:0]          init_type,
    input  logic [DATA_W-1:0]          init_data,
    output logic                       init_ready,
    input  logic                       ref_valid,
    input  logic [TYPE_W-1:0]          ref_type,
    input  logic [DATA_W-1:0]          ref_data,
    output logic                       ref_ready,
    input  logic [NUM_HOST-1:0]        host_valid,
    input  logic [NUM_HOST*TYPE_W-1:0] host_type,
    input  logic [NUM_HOST*DATA_W-1:0] host_data,
    output logic [NUM_HOST-1:0]        host_ready,
    output logic                       cmd_valid,
    output logic [TYPE_W-1:0]          cmd_type,
    output logic [DATA_W-1:0]          cmd_data,
    input  logic                       cmd_ready,
    output logic [ID_W-1:0]            grant_id,
    output logic                       ref_urgent
);

    localparam int RR_W  = $clog2(NUM_HOST);
    localparam int RRS_W = RR_W + 1;
    localparam int CNT_W = $clog2(REFRESH_MAX_WAIT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_MAX_WAIT);
    localparam logic [RR_W-1:0]  HOST_LAST = RR_W'(NUM_HOST - 1);
    localparam logic [RRS_W-1:0] HOST_CNT  = RRS_W'(NUM_HOST);
    localparam logic [ID_W-1:0]  REF_ID    = ID_W'(NUM_HOST);
    localparam logic [ID_W-1:0]  INIT_ID   = ID_W'(NUM_HOST + 1);

    localparam logic [1:0] ST_LOCKED = 2'd0;
    localparam logic [1:0] ST_NORMAL = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [RR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              ref_urgent_q, ref_urgent_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [TYPE_W-1:0] cmd_type_q, cmd_type_d;
    logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;

    logic                load_en_s;
    logic                host_hit_s;
    logic [RR_W-1:0]     host_idx_s;
    logic [RRS_W-1:0]    host_sum_s;
    logic                init_ready_s;
    logic                ref_ready_s;
    logic [NUM_HOST-1:0] host_ready_s;
    logic                host_grant_s;

    logic [TYPE_W-1:0] host_type_a [NUM_HOST];
    logic [DATA_W-1:0] host_data_a [NUM_HOST];

    for (genvar g = 0; g < NUM_HOST; g++) begin : g_unpack
        assign host_type_a[g] = host_type[g*TYPE_W +: TYPE_W];
        assign host_data_a[g] = host_data[g*DATA_W +: DATA_W];
    end

    assign load_en_s = !cmd_valid_q || cmd_ready;

    // Round-robin search: first valid host at or after rr_ptr, wrapping modulo NUM_HOST.
    always_comb begin
        host_hit_s = 1'b0;
        host_idx_s = '0;
        host_sum_s = '0;
        for (int k = 0; k < NUM_HOST; k++) begin
            host_sum_s = {1'b0, rr_ptr_q} + RRS_W'(k);
            if (host_sum_s >= HOST_CNT) begin
                host_sum_s = host_sum_s - HOST_CNT;
            end else begin
                host_sum_s = host_sum_s;
            end
            if (!host_hit_s && host_valid[host_sum_s[RR_W-1:0]]) begin
                host_hit_s = 1'b1;
                host_idx_s = host_sum_s[RR_W-1:0];
            end else begin
                host_hit_s = host_hit_s;
            end
        end
    end

    // Phase control and winner selection; a load only happens when the output register is free.
    always_comb begin
        state_d      = state_q;
        init_ready_s = 1'b0;
        ref_ready_s  = 1'b0;
        host_ready_s = '0;
        host_grant_s = 1'b0;
        case (state_q)
            ST_LOCKED: begin
                if (load_en_s && init_valid) begin
                    init_ready_s = 1'b1;
                end else begin
                    init_ready_s = 1'b0;
                end
                if (init_done && !init_busy && load_en_s) begin
                    state_d = ST_NORMAL;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            ST_NORMAL: begin
                if (init_busy) begin
                    state_d = ST_DRAIN;
                end else if (load_en_s) begin
                    if (ref_valid && ref_urgent_q) begin
                        ref_ready_s = 1'b1;
                    end else if (host_hit_s) begin
                        host_grant_s             = 1'b1;
                        host_ready_s[host_idx_s] = 1'b1;
                    end else if (ref_valid) begin
                        ref_ready_s = 1'b1;
                    end else begin
                        ref_ready_s = 1'b0;
                    end
                end else begin
                    state_d = ST_NORMAL;
                end
            end
            ST_DRAIN: begin
                if (load_en_s) begin
                    state_d = ST_LOCKED;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_LOCKED;
            end
        endcase
    end

    // Output register next state: load the winner, drop valid when accepted with nothing new.
    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_type_d  = cmd_type_q;
        cmd_data_d  = cmd_data_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (init_ready_s) begin
            cmd_valid_d = 1'b1;
            cmd_type_d  = init_type;
            cmd_data_d  = init_data;
            grant_id_d  = INIT_ID;
        end else if (ref_ready_s) begin
            cmd_valid_d = 1'b1;
            cmd_type_d  = ref_type;
            cmd_data_d  = ref_data;
            grant_id_d  = REF_ID;
        end else if (host_grant_s) begin
            cmd_valid_d = 1'b1;
            cmd_type_d  = host_type_a[host_idx_s];
            cmd_data_d  = host_data_a[host_idx_s];
            grant_id_d  = ID_W'(host_idx_s);
            rr_ptr_d    = (host_idx_s == HOST_LAST) ? '0 : host_idx_s + RR_W'(1);
        end else if (load_en_s) begin
            cmd_valid_d = 1'b0;
        end else begin
            cmd_valid_d = cmd_valid_q;
        end
    end

    // Refresh starvation counter; only time spent stalled in NORMAL counts towards urgency.
    always_comb begin
        if (!ref_valid || ref_ready_s) begin
            wait_cnt_d = '0;
        end else if (state_q == ST_NORMAL && wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
        ref_urgent_d = (wait_cnt_d == CNT_MAX);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOCKED;
            rr_ptr_q     <= '0;
            wait_cnt_q   <= '0;
            ref_urgent_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_type_q   <= '0;
            cmd_data_q   <= '0;
            grant_id_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            wait_cnt_q   <= wait_cnt_d;
            ref_urgent_q <= ref_urgent_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_type_q   <= cmd_type_d;
            cmd_data_q   <= cmd_data_d;
            grant_id_q   <= grant_id_d;
        end
    end

    assign init_ready = init_ready_s;
    assign ref_ready  = ref_ready_s;
    assign host_ready = host_ready_s;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_type   = cmd_type_q;
    assign cmd_data   = cmd_data_q;
    assign grant_id   = grant_id_q;
    assign ref_urgent = ref_urgent_q;

endmodule

// File: tb/tb_dram_cmd_arbiter.sv
// Scenario bench for dram_cmd_arbiter: directed scenarios plus a randomized run, all compared
// against a cycle-level reference model of the arbitration rules.
module tb_dram_cmd_arbiter;

    localparam int NH = 4;
    localparam int MW = 8;
    localparam int TW = 5;
    localparam int DW = 32;
    localparam int IW = 3;

    localparam int PH_LOCK  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_FLUSH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             init_busy, init_done, init_valid;
    logic [TW-1:0]    init_type;
    logic [DW-1:0]    init_data;
    logic             init_ready;
    logic             ref_valid;
    logic [TW-1:0]    ref_type;
    logic [DW-1:0]    ref_data;
    logic             ref_ready;
    logic [NH-1:0]    host_valid;
    logic [NH*TW-1:0] host_type;
    logic [NH*DW-1:0] host_data;
    logic [NH-1:0]    host_ready;
    logic             cmd_valid;
    logic [TW-1:0]    cmd_type;
    logic [DW-1:0]    cmd_data;
    logic             cmd_ready;
    logic [IW-1:0]    grant_id;
    logic             ref_urgent;

    int checks = 0;
    int errors = 0;

    // reference model state
    int            m_phase;
    int            m_next;
    int            m_wait;
    bit            m_urgent;
    bit            m_valid;
    logic [TW-1:0] m_type;
    logic [DW-1:0] m_data;
    int            m_id;
    // per-cycle expectations
    bit            e_init_r, e_ref_r, e_can_take;
    logic [NH-1:0] e_host_r;
    int            e_host_idx;

    dram_cmd_arbiter #(
        .NUM_HOST(NH), .REFRESH_MAX_WAIT(MW), .TYPE_W(TW), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .init_busy(init_busy), .init_done(init_done), .init_valid(init_valid),
        .init_type(init_type), .init_data(init_data), .init_ready(init_ready),
        .ref_valid(ref_valid), .ref_type(ref_type), .ref_data(ref_data), .ref_ready(ref_ready),
        .host_valid(host_valid), .host_type(host_type), .host_data(host_data),
        .host_ready(host_ready),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .grant_id(grant_id), .ref_urgent(ref_urgent)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = PH_LOCK; m_next = 0; m_wait = 0; m_urgent = 1'b0;
        m_valid = 1'b0; m_type = '0; m_data = '0; m_id = 0;
    endtask

    task automatic model_eval();
        e_init_r = 1'b0; e_ref_r = 1'b0; e_host_r = '0; e_host_idx = -1;
        e_can_take = !m_valid || cmd_ready;
        if (m_phase == PH_LOCK) begin
            e_init_r = e_can_take && init_valid;
        end else if (m_phase == PH_RUN && !init_busy && e_can_take) begin
            if (ref_valid && m_urgent) begin
                e_ref_r = 1'b1;
            end else begin
                for (int k = 0; k < NH; k++)
                    if (e_host_idx < 0 && host_valid[(m_next + k) % NH]) e_host_idx = (m_next + k) % NH;
                if (e_host_idx >= 0) e_host_r[e_host_idx] = 1'b1;
                else e_ref_r = ref_valid;
            end
        end
    endtask

    task automatic model_commit();
        if (e_init_r) begin
            m_type = init_type; m_data = init_data; m_id = NH + 1;
        end else if (e_ref_r) begin
            m_type = ref_type; m_data = ref_data; m_id = NH;
        end else if (e_host_idx >= 0) begin
            m_type = host_type[e_host_idx*TW +: TW];
            m_data = host_data[e_host_idx*DW +: DW];
            m_id   = e_host_idx;
            m_next = (e_host_idx + 1) % NH;
        end
        if (e_init_r || e_ref_r || e_host_idx >= 0) m_valid = 1'b1;
        else if (e_can_take) m_valid = 1'b0;
        if (!ref_valid || e_ref_r) m_wait = 0;
        else if (m_phase == PH_RUN && m_wait < MW) m_wait++;
        m_urgent = (m_wait == MW);
        case (m_phase)
            PH_LOCK:  if (init_done && !init_busy && e_can_take) m_phase = PH_RUN;
            PH_RUN:   if (init_busy) m_phase = PH_FLUSH;
            default:  if (e_can_take) m_phase = PH_LOCK;
        endcase
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic rand_payload();
        host_type = (NH*TW)'($urandom);
        host_data = {$urandom, $urandom, $urandom, $urandom};
        ref_data  = $urandom;
        init_data = $urandom;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        init_busy = 1'b0; init_done = 1'b0; init_valid = 1'b0; init_type = '0; init_data = '0;
        ref_valid = 1'b0; ref_type = '0; ref_data = '0;
        host_valid = '0; host_type = '0; host_data = '0; cmd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({cmd_valid, cmd_type, cmd_data, grant_id, ref_urgent} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b t=%0d d=%h id=%0d urg=%0b exp all 0",
                     cmd_valid, cmd_type, cmd_data, grant_id, ref_urgent);
        end
        checks++;
        if ({init_ready, ref_ready, host_ready} !== '0) begin
            errors++;
            $display("FAIL reset_readies got %b exp 0", {init_ready, ref_ready, host_ready});
        end
        model_reset();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_init_exclusive();
        init_busy = 1'b1; init_valid = 1'b1; init_type = 5'd1; host_valid = 4'hF; cmd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_payload();
            settle();
            checks++;
            if ({init_ready, ref_ready, host_ready} !== 6'b100000 ||
                {init_ready, ref_ready, host_ready} !== {e_init_r, e_ref_r, e_host_r}) begin
                errors++;
                $display("FAIL init_readies got %b exp 100000", {init_ready, ref_ready, host_ready});
            end
            advance();
            checks++;
            if (cmd_valid !== 1'b1 || cmd_type !== 5'd1 || grant_id !== 3'd5 || cmd_data !== m_data) begin
                errors++;
                $display("FAIL init_load got v=%0b t=%0d id=%0d d=%h exp v=1 t=1 id=5 d=%h",
                         cmd_valid, cmd_type, grant_id, cmd_data, m_data);
            end
        end
        init_valid = 1'b0; init_busy = 1'b0; init_done = 1'b1;
        settle();
        checks++;
        if (host_ready !== 4'b0000) begin
            errors++;
            $display("FAIL init_exit_hosts got %b exp 0000", host_ready);
        end
        advance();
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL init_exit_valid got %0b exp 0", cmd_valid);
        end
    endtask

    task automatic test_round_robin();
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        host_valid = 4'hF; cmd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_payload();
            settle();
            checks++;
            if (host_ready !== e_host_r || !$onehot(host_ready) || init_ready || ref_ready) begin
                errors++;
                $display("FAIL rr_ready[%0d] got %b exp %b", i, host_ready, e_host_r);
            end
            advance();
            checks++;
            if (grant_id !== IW'(exp_seq[i]) || grant_id !== IW'(m_id) || cmd_data !== m_data ||
                cmd_type !== m_type) begin
                errors++;
                $display("FAIL rr_grant[%0d] got id=%0d d=%h exp id=%0d d=%h",
                         i, grant_id, cmd_data, exp_seq[i], m_data);
            end
        end
    endtask

    task automatic test_refresh_escalation();
        int got_at = -1;
        host_valid = 4'hF; cmd_ready = 1'b1; ref_valid = 1'b1; ref_type = 5'd7;
        for (int i = 0; i < 12; i++) begin
            rand_payload();
            settle();
            checks++;
            if ({ref_ready, host_ready} !== {e_ref_r, e_host_r}) begin
                errors++;
                $display("FAIL refresh_ready[%0d] got %b exp %b", i, {ref_ready, host_ready},
                         {e_ref_r, e_host_r});
            end
            if (ref_ready === 1'b1 && got_at < 0) got_at = i;
            advance();
            checks++;
            if (ref_urgent !== m_urgent || grant_id !== IW'(m_id) || cmd_data !== m_data) begin
                errors++;
                $display("FAIL refresh_out[%0d] got urg=%0b id=%0d exp urg=%0b id=%0d",
                         i, ref_urgent, grant_id, m_urgent, m_id);
            end
        end
        checks++;
        if (got_at != MW) begin
            errors++;
            $display("FAIL refresh_escalation_cycle got %0d exp %0d", got_at, MW);
        end
        ref_valid = 1'b0;
        settle();
        advance();
    endtask

    task automatic test_stall_hold();
        logic [TW-1:0] held_type;
        logic [DW-1:0] held_data;
        int            held_id;
        host_valid = 4'hF; cmd_ready = 1'b1;
        rand_payload();
        settle();
        advance();
        held_type = m_type; held_data = m_data; held_id = m_id;
        cmd_ready = 1'b0; ref_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_payload();
            settle();
            checks++;
            if ({init_ready, ref_ready, host_ready} !== '0 ||
                {init_ready, ref_ready, host_ready} !== {e_init_r, e_ref_r, e_host_r}) begin
                errors++;
                $display("FAIL stall_ready[%0d] got %b exp 0", i, {init_ready, ref_ready, host_ready});
            end
            advance();
            checks++;
            if (cmd_valid !== 1'b1 || cmd_type !== held_type || cmd_data !== held_data ||
                grant_id !== IW'(held_id)) begin
                errors++;
                $display("FAIL stall_hold[%0d] got t=%0d d=%h id=%0d exp t=%0d d=%h id=%0d",
                         i, cmd_type, cmd_data, grant_id, held_type, held_data, held_id);
            end
        end
        cmd_ready = 1'b1; ref_valid = 1'b0;
        settle();
        advance();
    endtask

    task automatic test_drain();
        host_valid = 4'hF; cmd_ready = 1'b1;
        rand_payload();
        settle();
        advance();
        cmd_ready = 1'b0; init_busy = 1'b1; init_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if ({init_ready, ref_ready, host_ready} !== '0) begin
                errors++;
                $display("FAIL drain_ready[%0d] got %b exp 0", i, {init_ready, ref_ready, host_ready});
            end
            advance();
            checks++;
            if (cmd_valid !== 1'b1 || grant_id !== IW'(m_id)) begin
                errors++;
                $display("FAIL drain_hold[%0d] got v=%0b id=%0d exp v=1 id=%0d", i, cmd_valid, grant_id, m_id);
            end
        end
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++;
            if (host_ready !== 4'b0000) begin
                errors++;
                $display("FAIL drain_block[%0d] got %b exp 0000", i, host_ready);
            end
            advance();
            checks++;
            if (cmd_valid !== 1'b0 || cmd_valid !== m_valid) begin
                errors++;
                $display("FAIL drain_valid[%0d] got %0b exp 0", i, cmd_valid);
            end
        end
        init_busy = 1'b0; init_done = 1'b1;
        settle();
        checks++;
        if (host_ready !== 4'b0000) begin
            errors++;
            $display("FAIL drain_exit_block got %b exp 0000", host_ready);
        end
        advance();
        settle();
        checks++;
        if (host_ready !== e_host_r || host_ready === 4'b0000) begin
            errors++;
            $display("FAIL drain_resume got %b exp %b", host_ready, e_host_r);
        end
        advance();
        checks++;
        if (cmd_valid !== 1'b1 || grant_id !== IW'(m_id)) begin
            errors++;
            $display("FAIL drain_resume_out got v=%0b id=%0d exp v=1 id=%0d", cmd_valid, grant_id, m_id);
        end
    endtask

    task automatic test_async_reset();
        host_valid = 4'b0100; cmd_ready = 1'b1;
        rand_payload();
        settle();
        advance();
        host_valid = 4'hF; cmd_ready = 1'b0;
        settle();
        advance();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cmd_valid !== 1'b0 || grant_id !== '0 || cmd_type !== '0) begin
            errors++;
            $display("FAIL async_reset got v=%0b id=%0d t=%0d exp 0 0 0", cmd_valid, grant_id, cmd_type);
        end
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        cmd_ready = 1'b1;
        settle();
        checks++;
        if (host_ready !== 4'b0000) begin
            errors++;
            $display("FAIL async_locked got %b exp 0000", host_ready);
        end
        advance();
        settle();
        checks++;
        if (host_ready !== 4'b0001 || host_ready !== e_host_r) begin
            errors++;
            $display("FAIL async_rr_ptr got %b exp 0001", host_ready);
        end
        advance();
        checks++;
        if (grant_id !== 3'd0 || cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_first_grant got id=%0d v=%0b exp id=0 v=1", grant_id, cmd_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            init_busy  = ($urandom_range(0, 15) == 0);
            init_done  = ($urandom_range(0, 3) != 0);
            init_valid = $urandom_range(0, 1);
            init_type  = TW'($urandom);
            ref_valid  = ($urandom_range(0, 2) != 0);
            ref_type   = TW'($urandom);
            host_valid = NH'($urandom);
            cmd_ready  = ($urandom_range(0, 9) < 7);
            rand_payload();
            settle();
            checks++;
            if ({init_ready, ref_ready, host_ready} !== {e_init_r, e_ref_r, e_host_r}) begin
                errors++;
                $display("FAIL random_ready[%0d] got %b exp %b", i, {init_ready, ref_ready, host_ready},
                         {e_init_r, e_ref_r, e_host_r});
            end
            advance();
            checks++;
            if (cmd_valid !== m_valid || cmd_type !== m_type || cmd_data !== m_data ||
                grant_id !== IW'(m_id) || ref_urgent !== m_urgent) begin
                errors++;
                $display("FAIL random_out[%0d] got v=%0b t=%0d d=%h id=%0d urg=%0b exp v=%0b t=%0d d=%h id=%0d urg=%0b",
                         i, cmd_valid, cmd_type, cmd_data, grant_id, ref_urgent,
                         m_valid, m_type, m_data, m_id, m_urgent);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init_exclusive();
        test_round_robin();
        test_refresh_escalation();
        test_stall_hold();
        test_drain();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

endmodule
